// File: rtl/hi_host_master.sv
// Host-side master for the HI word bus: sends a 4-word command header, then streams
// write words from the host or read words from the device, with a stall timeout.
module hi_host_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        if_clock,
    input  logic        resetb,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    output logic        cmd_ready,
    input  logic [15:0] cmd_ep,
    input  logic [15:0] cmd_reg,
    input  logic [15:0] cmd_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        timeout_err,
    output logic [2:0]  ctl,
    input  logic        rdy,
    input  logic        hi_out,
    inout  wire  [15:0] data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [2:0] CTL_IDLE = 3'b000;
    localparam logic [2:0] CTL_CMD  = 3'b001;
    localparam logic [2:0] CTL_WR   = 3'b010;
    localparam logic [2:0] CTL_RD   = 3'b100;

    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_r, state_nxt_s;
    logic          write_r;
    logic [15:0]   ep_r, reg_r, len_r, rem_r;
    logic [1:0]    hdr_idx_r;
    logic [TW-1:0] to_cnt_r;
    logic [15:0]   rd_data_r;
    logic          rd_valid_r;
    logic [2:0]    ctl_s;
    logic          xfer_s;
    logic          timeout_hit_s;
    logic [15:0]   hdr_word_s;
    logic [15:0]   drv_word_s;
    logic          drive_s;

    // Bus phase and per-state transfer condition.
    always_comb begin
        ctl_s  = CTL_IDLE;
        xfer_s = 1'b0;
        case (state_r)
            S_HDR: begin
                ctl_s  = CTL_CMD;
                xfer_s = rdy;
            end
            S_WR: begin
                ctl_s  = wr_valid ? CTL_WR : CTL_IDLE;
                xfer_s = wr_valid && rdy && !hi_out;
            end
            S_RD: begin
                ctl_s  = CTL_RD;
                xfer_s = rdy && hi_out;
            end
            default: begin
                ctl_s  = CTL_IDLE;
                xfer_s = 1'b0;
            end
        endcase
    end

    assign timeout_hit_s = (ctl_s != CTL_IDLE) && !xfer_s && (to_cnt_r == TO_LAST);

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) state_nxt_s = S_HDR;
                else           state_nxt_s = S_IDLE;
            end
            S_HDR: begin
                if (timeout_hit_s)                   state_nxt_s = S_ERR;
                else if (xfer_s && hdr_idx_r == 2'd3) begin
                    if (len_r == 16'd0)              state_nxt_s = S_FIN;
                    else if (write_r)                state_nxt_s = S_WR;
                    else                             state_nxt_s = S_RD;
                end else                             state_nxt_s = S_HDR;
            end
            S_WR, S_RD: begin
                if (timeout_hit_s)                    state_nxt_s = S_ERR;
                else if (xfer_s && rem_r == 16'd1)    state_nxt_s = S_FIN;
                else                                  state_nxt_s = state_r;
            end
            S_FIN:   state_nxt_s = S_IDLE;
            S_ERR:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Header word mux and host-side data drive.
    always_comb begin
        case (hdr_idx_r)
            2'd0:    hdr_word_s = {15'b0, write_r};
            2'd1:    hdr_word_s = ep_r;
            2'd2:    hdr_word_s = reg_r;
            2'd3:    hdr_word_s = len_r;
            default: hdr_word_s = 16'd0;
        endcase
        if (state_r == S_WR) drv_word_s = wr_data;
        else                 drv_word_s = hdr_word_s;
    end

    assign drive_s     = ((ctl_s == CTL_CMD) || (ctl_s == CTL_WR)) && !hi_out;
    assign data        = drive_s ? drv_word_s : 16'bz;
    assign ctl         = ctl_s;
    assign cmd_ready   = (state_r == S_IDLE);
    assign wr_ready    = (state_r == S_WR) && wr_valid && rdy && !hi_out;
    assign done        = (state_r == S_FIN) || (state_r == S_ERR);
    assign timeout_err = (state_r == S_ERR);
    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;

    // State, command latch, header index and remaining-word count.
    always_ff @(posedge if_clock) begin
        if (!resetb) begin
            state_r   <= S_IDLE;
            write_r   <= 1'b0;
            ep_r      <= 16'd0;
            reg_r     <= 16'd0;
            len_r     <= 16'd0;
            rem_r     <= 16'd0;
            hdr_idx_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_IDLE && cmd_valid) begin
                write_r <= cmd_write;
                ep_r    <= cmd_ep;
                reg_r   <= cmd_reg;
                len_r   <= cmd_len;
                rem_r   <= cmd_len;
            end else if ((state_r == S_WR || state_r == S_RD) && xfer_s) begin
                rem_r <= rem_r - 16'd1;
            end
            if (state_r != S_HDR) hdr_idx_r <= 2'd0;
            else if (xfer_s)      hdr_idx_r <= hdr_idx_r + 2'd1;
        end
    end

    // Stall counter: holds while the host has nothing to write (ctl idle).
    always_ff @(posedge if_clock) begin
        if (!resetb)                       to_cnt_r <= '0;
        else if (state_nxt_s != state_r)   to_cnt_r <= '0;
        else if (xfer_s)                   to_cnt_r <= '0;
        else if (ctl_s != CTL_IDLE)        to_cnt_r <= to_cnt_r + TW'(1);
        else                               to_cnt_r <= to_cnt_r;
    end

    // Read capture with a one-cycle valid strobe.
    always_ff @(posedge if_clock) begin
        if (!resetb) begin
            rd_data_r  <= 16'd0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == S_RD) && xfer_s;
            if ((state_r == S_RD) && xfer_s) rd_data_r <= data;
        end
    end

endmodule

// File: tb/tb_hi_host_master.sv
// Scoreboard bench for hi_host_master: expected bus/read words are queued when a
// command is issued and popped as the monitor sees them transfer.
module tb_hi_host_master;

    logic        if_clock = 1'b0;
    logic        resetb   = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [15:0] cmd_ep = 16'd0, cmd_reg = 16'd0, cmd_len = 16'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, done, timeout_err;
    logic [2:0]  ctl;
    logic        rdy = 1'b1;
    logic        hi_out;
    logic        dev_oe = 1'b0;
    logic [15:0] dev_data = 16'd0;
    wire  [15:0] data;

    assign data   = dev_oe ? dev_data : 16'bz;
    assign hi_out = dev_oe;

    hi_host_master #(.TIMEOUT_CYCLES(16)) dut (
        .if_clock(if_clock), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_ready(cmd_ready),
        .cmd_ep(cmd_ep), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .timeout_err(timeout_err),
        .ctl(ctl), .rdy(rdy), .hi_out(hi_out), .data(data)
    );

    always #5 if_clock = ~if_clock;

    int checks = 0, errors = 0;
    int cyc = 0;
    int done_cnt = 0, tmo_cnt = 0, rd_cnt = 0, hdr_cnt = 0, ctl_rd_cnt = 0, last_hdr_cyc = 0;
    logic [15:0] bus_q[$];
    logic [15:0] rd_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge if_clock);
        cyc++;
    end

    // Monitor: bus words and read results against the scoreboard queues.
    initial forever begin
        @(negedge if_clock);
        if (done) done_cnt++;
        if (timeout_err) tmo_cnt++;
        if (resetb) begin
            if ((ctl == 3'b001 && rdy) || (ctl == 3'b010 && rdy && !hi_out)) begin
                if (ctl == 3'b001) begin
                    hdr_cnt++;
                    last_hdr_cyc = cyc;
                end else begin
                    check_val("wr_ready", {31'b0, wr_ready}, 32'd1);
                end
                if (bus_q.size() == 0) check_val("bus_extra", 32'(bus_q.size()), 32'd1);
                else                   check_val("bus_word", {16'b0, data}, {16'b0, bus_q.pop_front()});
            end
            if (ctl == 3'b100) ctl_rd_cnt++;
            if (rd_valid) begin
                rd_cnt++;
                if (rd_q.size() == 0) check_val("rd_extra", 32'(rd_q.size()), 32'd1);
                else                  check_val("rd_data", {16'b0, rd_data}, {16'b0, rd_q.pop_front()});
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [15:0] ep, input logic [15:0] rg,
                            input logic [15:0] len, input bit push_hdr);
        bit ok = 0;
        @(posedge if_clock); #1;
        cmd_write = w; cmd_ep = ep; cmd_reg = rg; cmd_len = len; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge if_clock);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) check_val("cmd_ready", {31'b0, cmd_ready}, 32'd1);
        if (push_hdr) begin
            bus_q.push_back({15'b0, w});
            bus_q.push_back(ep);
            bus_q.push_back(rg);
            bus_q.push_back(len);
        end
        @(posedge if_clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_wr(input logic [15:0] w);
        bit ok = 0;
        wr_data = w; wr_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge if_clock);
            if (wr_ready) begin ok = 1; break; end
        end
        if (!ok) check_val("wr_accept", {31'b0, wr_ready}, 32'd1);
        @(posedge if_clock); #1;
    endtask

    task automatic wait_ctl(input logic [2:0] v);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge if_clock);
            if (ctl == v) begin ok = 1; break; end
        end
        if (!ok) check_val("wait_ctl", {29'b0, ctl}, {29'b0, v});
    endtask

    task automatic wait_done(input int budget, output int at_cyc, output logic tmo,
                             output logic [2:0] ctl_at, output int stalls);
        bit ok = 0;
        stalls = 0; at_cyc = 0; tmo = 1'b0; ctl_at = 3'b111;
        for (int i = 0; i < budget; i++) begin
            @(negedge if_clock);
            if (ctl == 3'b001 && !rdy) stalls++;
            if (done) begin
                ok = 1; at_cyc = cyc; tmo = timeout_err; ctl_at = ctl;
                break;
            end
        end
        if (!ok) check_val("done_seen", {31'b0, done}, 32'd1);
    endtask

    int          at_cyc, stalls, d0, t0, r0, h0, c0;
    logic        tmo;
    logic [2:0]  ctl_at;

    initial begin
        // Reset state.
        repeat (3) @(posedge if_clock);
        @(negedge if_clock);
        check_val("rst_ctl", {29'b0, ctl}, 32'd0);
        check_val("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check_val("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        check_val("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check_val("rst_rd_data", {16'b0, rd_data}, 32'd0);
        check_val("rst_done", {30'b0, done, timeout_err}, 32'd0);
        check_val("rst_data_z", {31'b0, data === 16'hzzzz}, 32'd1);
        @(posedge if_clock); #1;
        resetb = 1'b1;

        // Write of two words with rdy always high.
        d0 = done_cnt;
        send_cmd(1'b1, 16'h0001, 16'h0002, 16'd2, 1'b1);
        bus_q.push_back(16'hA5A5);
        bus_q.push_back(16'h5A5A);
        drive_wr(16'hA5A5);
        drive_wr(16'h5A5A);
        wr_valid = 1'b0;
        wait_done(50, at_cyc, tmo, ctl_at, stalls);
        check_val("wr_tmo", {31'b0, tmo}, 32'd0);
        repeat (3) @(negedge if_clock);
        check_val("wr_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_val("wr_q_empty", 32'(bus_q.size()), 32'd0);

        // Read of three words, each preceded by 7 rdy-low cycles.
        r0 = rd_cnt;
        send_cmd(1'b0, 16'h0003, 16'h0004, 16'd3, 1'b1);
        for (int k = 1; k <= 3; k++) rd_q.push_back(16'(k));
        wait_ctl(3'b100);
        for (int k = 1; k <= 3; k++) begin
            rdy = 1'b0; dev_oe = 1'b1; dev_data = 16'(k);
            repeat (7) @(posedge if_clock);
            #1 rdy = 1'b1;
            @(posedge if_clock); #1;
        end
        dev_oe = 1'b0; rdy = 1'b1;
        wait_done(50, at_cyc, tmo, ctl_at, stalls);
        check_val("rd_tmo", {31'b0, tmo}, 32'd0);
        check_val("rd_pulses", 32'(rd_cnt - r0), 32'd3);
        check_val("rd_q_empty", 32'(rd_q.size()), 32'd0);

        // Zero-length read: header only, done right after the last header word.
        h0 = hdr_cnt; c0 = ctl_rd_cnt;
        send_cmd(1'b0, 16'h0005, 16'h0006, 16'd0, 1'b1);
        wait_done(50, at_cyc, tmo, ctl_at, stalls);
        check_val("len0_hdr_words", 32'(hdr_cnt - h0), 32'd4);
        check_val("len0_no_rd_phase", 32'(ctl_rd_cnt - c0), 32'd0);
        check_val("len0_done_cycle", 32'(at_cyc), 32'(last_hdr_cyc + 1));

        // Header stalled by rdy low: timeout after 16 stalled cycles.
        t0 = tmo_cnt;
        rdy = 1'b0;
        send_cmd(1'b1, 16'h0007, 16'h0008, 16'd1, 1'b0);
        wait_done(100, at_cyc, tmo, ctl_at, stalls);
        check_val("to_stall_cycles", 32'(stalls), 32'd16);
        check_val("to_err_with_done", {31'b0, tmo}, 32'd1);
        check_val("to_ctl_idle", {29'b0, ctl_at}, 32'd0);
        check_val("to_data_z", {31'b0, data === 16'hzzzz}, 32'd1);
        rdy = 1'b1;
        send_cmd(1'b0, 16'h0009, 16'h000A, 16'd0, 1'b1);
        wait_done(50, at_cyc, tmo, ctl_at, stalls);
        check_val("to_next_cmd_tmo", {31'b0, tmo}, 32'd0);
        check_val("to_err_pulses", 32'(tmo_cnt - t0), 32'd1);

        // Host starvation mid-write must not time out; new command is held off.
        t0 = tmo_cnt;
        send_cmd(1'b1, 16'h0011, 16'h0012, 16'd3, 1'b1);
        bus_q.push_back(16'h1111);
        bus_q.push_back(16'h2222);
        bus_q.push_back(16'h3333);
        drive_wr(16'h1111);
        wr_valid = 1'b0;
        cmd_valid = 1'b1;
        repeat (3000) @(posedge if_clock);
        @(negedge if_clock);
        check_val("starve_cmd_held", {31'b0, cmd_ready}, 32'd0);
        check_val("starve_ctl_idle", {29'b0, ctl}, 32'd0);
        check_val("starve_no_tmo", 32'(tmo_cnt - t0), 32'd0);
        cmd_valid = 1'b0;
        @(posedge if_clock); #1;
        drive_wr(16'h2222);
        drive_wr(16'h3333);
        wr_valid = 1'b0;
        wait_done(50, at_cyc, tmo, ctl_at, stalls);
        check_val("starve_done_tmo", {31'b0, tmo}, 32'd0);
        check_val("starve_q_empty", 32'(bus_q.size()), 32'd0);

        // Reset during read word 2 of 5 aborts silently.
        send_cmd(1'b0, 16'h0001, 16'h0002, 16'd5, 1'b1);
        rd_q.push_back(16'h00AA);
        wait_ctl(3'b100);
        dev_oe = 1'b1; dev_data = 16'h00AA; rdy = 1'b1;
        @(posedge if_clock); #1;
        dev_data = 16'h00BB; rdy = 1'b0;
        repeat (2) @(posedge if_clock);
        #1;
        d0 = done_cnt; t0 = tmo_cnt;
        resetb = 1'b0; dev_oe = 1'b0;
        @(posedge if_clock);
        @(negedge if_clock);
        check_val("abort_ctl", {29'b0, ctl}, 32'd0);
        check_val("abort_data_z", {31'b0, data === 16'hzzzz}, 32'd1);
        check_val("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check_val("abort_rd_valid", {31'b0, rd_valid}, 32'd0);
        @(posedge if_clock); #1;
        resetb = 1'b1; rdy = 1'b1;
        repeat (5) @(negedge if_clock);
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("abort_no_tmo", 32'(tmo_cnt - t0), 32'd0);
        check_val("abort_rd_q", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hi_host_master.md
HI_HOST_MASTER -- requirements
Module: hi_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning consecutive rdy-low cycles with a phase asserted before abort.
REQ-002 SHALL have port if_clock  input  1  interface clock; all logic on rising edge.
REQ-003 SHALL have port resetb  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cmd_valid, cmd_write  input  1 each; cmd_ready  output  1.
REQ-005 SHALL have ports cmd_ep, cmd_reg, cmd_len  input  16 each (cmd_len in 16-bit words).
REQ-006 SHALL have ports wr_data  input  16; wr_valid  input  1; wr_ready  output  1.
REQ-007 SHALL have ports rd_data  output  16; rd_valid  output  1.
REQ-008 SHALL have ports done, timeout_err  output  1 each.
REQ-009 SHALL have ports ctl  output  3; rdy  input  1; hi_out  input  1 (device drives data when 1); data  inout  16.

Function
REQ-010 SHALL encode ctl as: 3'b000 idle, 3'b001 command word, 3'b010 write word, 3'b100 read word.
REQ-011 SHALL transfer one word on each rising edge where ctl is non-idle and rdy==1; rdy==0 stalls, holding ctl and data.
REQ-012 SHALL drive data only when ctl is 3'b001 or 3'b010 and hi_out==0; otherwise data SHALL be high-Z.
REQ-013 SHALL implement states IDLE, HDR, WR, RD, FIN, ERR.
REQ-014 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, SHALL latch write/ep/reg/len and go to HDR next cycle.
REQ-015 HDR: ctl=3'b001; SHALL send, in order, {15'b0,cmd_write}, cmd_ep, cmd_reg, cmd_len (4 words).
REQ-016 After the 4th header word: len==0 -> FIN; else write -> WR, read -> RD.
REQ-017 WR: ctl=3'b010 only while wr_valid==1, else 3'b000; data=wr_data; wr_ready = (state==WR) && wr_valid && rdy && !hi_out.
REQ-018 WR: each wr_valid&&wr_ready consumes one word and decrements the remaining count; at count 0 -> FIN.
REQ-019 RD: ctl=3'b100; a word is accepted when rdy==1 and hi_out==1; rd_data SHALL register data, with rd_valid high for exactly one cycle on the following edge.
REQ-020 RD: no backpressure; the consumer SHALL accept every rd_valid pulse; at count 0 -> FIN.
REQ-021 Remaining count SHALL be 16-bit unsigned; cmd_len=16'hFFFF transfers 65535 words without wrap.
REQ-022 FIN: ctl=3'b000; done SHALL pulse high for 1 cycle; next state IDLE.
REQ-023 Timeout counter SHALL count cycles where ctl!=0 and the word does not transfer; it clears on every transfer and on entering any state.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 and the word does not transfer, SHALL go to ERR.
REQ-025 ERR: ctl=3'b000, bus released; done and timeout_err SHALL pulse together for 1 cycle; next state IDLE.
REQ-026 In WR with wr_valid==0, the timeout counter SHALL hold (host starvation is not a timeout).
REQ-027 cmd_ready SHALL be 0 in every state except IDLE; commands presented during a transfer SHALL be held off, not dropped.

Reset
REQ-028 On resetb==0 at an edge: state=IDLE, ctl=0, data high-Z, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, timeout_err=0, counters=0.
REQ-029 Reset mid-transfer SHALL abort immediately without pulsing done or timeout_err.

Verification
REQ-030 Write ep=16'h0001 reg=16'h0002 len=2 data 16'hA5A5, 16'h5A5A, rdy=1 -> data sees 0001,0001,0002,0002,A5A5,5A5A; one done pulse; timeout_err=0.
REQ-031 Read len=3 with device returning 1,2,3 and 7 rdy-low cycles before each word -> rd_valid pulses 3 times with rd_data 1,2,3; then done.
REQ-032 len=0 read -> exactly 4 header words, no ctl=3'b100 cycle, done one cycle after the last header word.
REQ-033 rdy held 0 in HDR, TIMEOUT_CYCLES=16 -> ERR after 16 stalled cycles; done and timeout_err pulse together; ctl=0; next command accepted.
REQ-034 WR with wr_valid deasserted for 3000 cycles mid-transfer -> no timeout; transfer completes when wr_valid resumes.
REQ-035 resetb low during RD word 2 of 5 -> ctl=0 next cycle; no done; data high-Z; cmd_ready=1.
